// File: rtl/mem_pkg.sv
// Shared definitions for the riscv-mini data-memory path: access-size codes,
// responder state encoding, opcodes and the lane/extension helpers.
package mem_pkg;

  // funct3 access size / signedness codes
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Load/store major opcodes, shared with control decode
  localparam logic [6:0] L_OP = 7'b0000011;
  localparam logic [6:0] S_OP = 7'b0100011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  // Loads accept all five size codes; stores have no unsigned variants.
  function automatic logic f3_legal(input logic [2:0] f3, input logic is_store);
    logic ok;
    ok = 1'b0;
    case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = ~is_store;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Natural alignment: halves on even bytes, words on 4-byte boundaries.
  function automatic logic f3_aligned(input logic [2:0] f3, input logic [1:0] a);
    logic ok;
    ok = 1'b1;
    case (f3)
      F3_H, F3_HU: ok = ~a[0];
      F3_W:        ok = (a == 2'b00);
      default:     ok = 1'b1;
    endcase
    return ok;
  endfunction

  // Byte-enable mask for a store of the given size at byte offset a.
  function automatic logic [3:0] f3_byte_en(input logic [2:0] f3, input logic [1:0] a);
    logic [3:0] be;
    be = 4'b1111;
    case (f3)
      F3_B, F3_BU: be = 4'b0001 << a;
      F3_H, F3_HU: be = a[1] ? 4'b1100 : 4'b0011;
      default:     be = 4'b1111;
    endcase
    return be;
  endfunction

  // Replicate right-aligned store data onto every lane; the byte enables pick one.
  function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] w;
    w = d;
    case (f3)
      F3_B, F3_BU: w = {4{d[7:0]}};
      F3_H, F3_HU: w = {2{d[15:0]}};
      default:     w = d;
    endcase
    return w;
  endfunction

  // Shift the addressed lane down to bit 0, then sign- or zero-extend it.
  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [2:0] f3,
                                              input logic [1:0] a);
    logic [31:0] sh;
    logic [31:0] res;
    sh  = word >> {a, 3'b000};
    res = sh;
    case (f3)
      F3_B:    res = {{24{sh[7]}}, sh[7:0]};
      F3_BU:   res = {24'h0, sh[7:0]};
      F3_H:    res = {{16{sh[15]}}, sh[15:0]};
      F3_HU:   res = {16'h0, sh[15:0]};
      default: res = sh;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised single-port RAM with per-byte write enables and a registered read.
module dmem_array #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          en_i,
  input  logic [3:0]    we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_rdata;

  // Byte-enabled write or registered read of the addressed word.
  // NOTE: the storage array has no reset so it maps onto RAM macros; contents are
  // undefined until written.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      for (int b = 0; b < 4; b++) begin
        if (we_i[b]) r_mem[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
      if (we_i == 4'b0000) r_rdata <= r_mem[addr_i];
    end
  end

  assign rdata_o = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time from the core, waits
// LATENCY cycles, commits against the RAM and strobes ready for one cycle.
module dmem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] rdata_o,
  output logic        ready_o,
  output logic        busy_o,
  output logic        err_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LAT_M1_INT = (LATENCY > 0) ? LATENCY - 1 : 0;
  localparam logic [3:0] LAT_M1 = LAT_M1_INT[3:0];

  dmem_state_t   r_state;
  logic [3:0]    r_cnt;
  logic [AW+1:0] r_addr;
  logic [31:0]   r_wdata;
  logic [2:0]    r_funct3;
  logic          r_is_store;

  logic          w_idle;
  logic          w_req;
  logic          w_bad;
  logic          w_accept;
  logic          w_reject;
  logic          w_commit;
  logic [AW+1:0] w_sel_addr;
  logic [31:0]   w_sel_wdata;
  logic [2:0]    w_sel_f3;
  logic          w_sel_store;
  logic [3:0]    w_ram_we;
  logic [31:0]   w_ram_wdata;
  logic [31:0]   w_ram_rdata;
  logic          w_unused_addr_bits;

  // Address bits above the RAM index wrap away.
  assign w_unused_addr_bits = ^addr_i[31:AW+2];

  // Request decode: reset masks the request so every output stays low in reset.
  assign w_idle   = (r_state == IDLE);
  assign w_req    = ~rst_i & (mem_read_i | mem_write_i);
  assign w_bad    = (mem_read_i & mem_write_i)
                  | ~f3_legal(funct3_i, mem_write_i)
                  | ~f3_aligned(funct3_i, addr_i[1:0]);
  assign w_accept = w_idle & w_req & ~w_bad;
  assign w_reject = w_idle & w_req & w_bad;

  // Commit happens on the last WAIT cycle, or on the acceptance edge itself when
  // there are no wait states, in which case the live inputs are still the source.
  assign w_commit    = ((r_state == WAIT) && (r_cnt == 4'd0)) || (w_accept && (LATENCY == 0));
  assign w_sel_addr  = w_idle ? addr_i[AW+1:0] : r_addr;
  assign w_sel_wdata = w_idle ? wdata_i        : r_wdata;
  assign w_sel_f3    = w_idle ? funct3_i       : r_funct3;
  assign w_sel_store = w_idle ? mem_write_i    : r_is_store;

  assign w_ram_we    = (w_commit && w_sel_store) ? f3_byte_en(w_sel_f3, w_sel_addr[1:0]) : 4'b0000;
  assign w_ram_wdata = store_lanes(w_sel_f3, w_sel_wdata);

  dmem_array #(
    .DEPTH (DEPTH)
  ) u_array (
    .clk_i   (clk_i),
    .en_i    (w_commit),
    .we_i    (w_ram_we),
    .addr_i  (w_sel_addr[AW+1:2]),
    .wdata_i (w_ram_wdata),
    .rdata_o (w_ram_rdata)
  );

  // Responder FSM: latch the accepted request, count wait states, respond once.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values and simulation matches the synthesized netlist.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= IDLE;
      r_cnt      <= 4'd0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_funct3   <= F3_B;
      r_is_store <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_addr     <= addr_i[AW+1:0];
            r_wdata    <= wdata_i;
            r_funct3   <= funct3_i;
            r_is_store <= mem_write_i;
            if (LATENCY == 0) begin
              r_state <= RESP;
            end else begin
              r_state <= WAIT;
              r_cnt   <= LAT_M1;
            end
          end
        end
        WAIT: begin
          if (r_cnt == 4'd0) r_state <= RESP;
          else               r_cnt   <= r_cnt - 4'd1;
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ready_o = (r_state == RESP) | w_reject;
  assign err_o   = w_reject;
  assign busy_o  = w_accept | (r_state == WAIT);

  // Load result is only driven during a load's RESP cycle.
  // NOTE: the output gets a default before the condition so no latch is inferred.
  always_comb begin
    rdata_o = '0;
    if ((r_state == RESP) && !r_is_store) begin
      rdata_o = load_extend(w_ram_rdata, r_funct3, r_addr[1:0]);
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench: a LATENCY=0 / DEPTH=64 responder and a LATENCY=2 /
// DEPTH=1024 responder, each with its own request port and byte-level model.
module tb_dmem_responder;
  import mem_pkg::*;

  localparam int D0_DEPTH = 64;
  localparam int D1_DEPTH = 1024;
  localparam int LAT [2] = '{0, 2};

  logic        clk = 1'b0;
  logic        rst      [2];
  logic        rd       [2];
  logic        wr       [2];
  logic [31:0] addr     [2];
  logic [31:0] wdata    [2];
  logic [2:0]  funct3   [2];
  logic [31:0] rdata    [2];
  logic        ready    [2];
  logic        busy     [2];
  logic        err      [2];

  int n_vec = 0;
  int n_bad = 0;

  logic [7:0] mdl_mem [2][4096];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(D0_DEPTH), .LATENCY(0)) u_lat0 (
    .clk_i(clk), .rst_i(rst[0]), .mem_read_i(rd[0]), .mem_write_i(wr[0]),
    .addr_i(addr[0]), .wdata_i(wdata[0]), .funct3_i(funct3[0]),
    .rdata_o(rdata[0]), .ready_o(ready[0]), .busy_o(busy[0]), .err_o(err[0])
  );

  dmem_responder #(.DEPTH(D1_DEPTH), .LATENCY(2)) u_lat2 (
    .clk_i(clk), .rst_i(rst[1]), .mem_read_i(rd[1]), .mem_write_i(wr[1]),
    .addr_i(addr[1]), .wdata_i(wdata[1]), .funct3_i(funct3[1]),
    .rdata_o(rdata[1]), .ready_o(ready[1]), .busy_o(busy[1]), .err_o(err[1])
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // ---------------- behavioural reference model (byte-addressed) ----------------
  function automatic int mdl_bytes(input int d);
    return (d == 0) ? 4 * D0_DEPTH : 4 * D1_DEPTH;
  endfunction

  function automatic bit mdl_legal(input logic r, input logic w, input logic [2:0] f3,
                                   input logic [31:0] a);
    int sz;
    if (r && w) return 1'b0;
    if (f3 == 3'd3 || f3 > 3'd5) return 1'b0;
    if (w && f3[2]) return 1'b0;
    sz = 1 << f3[1:0];
    return (a % sz) == 0;
  endfunction

  function automatic logic [31:0] mdl_load(input int d, input logic [2:0] f3, input logic [31:0] a);
    int sz;
    int base;
    logic [31:0] v;
    sz   = 1 << f3[1:0];
    base = int'(a % mdl_bytes(d));
    v    = '0;
    for (int i = 0; i < sz; i++) v = v | (32'(mdl_mem[d][base + i]) << (8 * i));
    if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | ~((32'd1 << (8 * sz)) - 32'd1);
    return v;
  endfunction

  task automatic mdl_store(input int d, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd);
    int sz;
    int base;
    sz   = 1 << f3[1:0];
    base = int'(a % mdl_bytes(d));
    for (int i = 0; i < sz; i++) mdl_mem[d][base + i] = wd[8*i +: 8];
  endtask

  // ---------------- one request on port d, held until ready ----------------
  task automatic xact(input int d, input logic r, input logic w, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd,
                      output logic [31:0] got_rdata, output logic got_err,
                      output int lat, output int nbusy, output logic leak);
    got_rdata = '0;
    got_err   = 1'b0;
    lat       = -1;
    nbusy     = 0;
    leak      = 1'b0;
    @(negedge clk);
    rd[d] = r; wr[d] = w; funct3[d] = f3; addr[d] = a; wdata[d] = wd;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (busy[d]) nbusy++;
      if (ready[d]) begin
        got_rdata = rdata[d];
        got_err   = err[d];
        lat       = c;
        break;
      end
      if (rdata[d] != 32'h0 || err[d]) leak = 1'b1;
      @(negedge clk);
    end
    rd[d] = 1'b0; wr[d] = 1'b0;
  endtask

  task automatic run_and_check(input string tag, input int d, input logic r, input logic w,
                               input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                               input logic [31:0] exp_rdata, input logic exp_err);
    logic [31:0] got;
    logic        gerr;
    logic        leak;
    int          lat;
    int          nbusy;
    int          exp_lat;
    xact(d, r, w, f3, a, wd, got, gerr, lat, nbusy, leak);
    exp_lat = exp_err ? 0 : LAT[d] + 1;
    check({tag, " rdata"}, got, exp_rdata);
    check({tag, " err"}, 32'(gerr), 32'(exp_err));
    check({tag, " ready_cycle"}, lat, exp_lat);
    check({tag, " busy_cycles"}, nbusy, exp_lat);
    check({tag, " quiet_before_ready"}, 32'(leak), 32'h0);
  endtask

  typedef struct {
    int          d;
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vt [18];

  initial begin
    logic        seen;
    logic [31:0] a;
    logic [31:0] wd;
    logic [2:0]  f3;
    logic        r;
    logic        w;
    logic        leg;
    logic [31:0] exp_rd;
    int          base;
    int          sel;

    vt[0]  = '{1, 1'b0, 1'b1, F3_W,   32'h10,  32'hDEADBEEF, 32'h0,        1'b0};
    vt[1]  = '{1, 1'b1, 1'b0, F3_W,   32'h10,  32'h0,        32'hDEADBEEF, 1'b0};
    vt[2]  = '{1, 1'b0, 1'b1, F3_B,   32'h13,  32'h80,       32'h0,        1'b0};
    vt[3]  = '{1, 1'b1, 1'b0, F3_B,   32'h13,  32'h0,        32'hFFFFFF80, 1'b0};
    vt[4]  = '{1, 1'b1, 1'b0, F3_BU,  32'h13,  32'h0,        32'h00000080, 1'b0};
    vt[5]  = '{1, 1'b1, 1'b0, F3_W,   32'h10,  32'h0,        32'h80ADBEEF, 1'b0};
    vt[6]  = '{1, 1'b0, 1'b1, F3_H,   32'h22,  32'h8001,     32'h0,        1'b0};
    vt[7]  = '{1, 1'b1, 1'b0, F3_H,   32'h22,  32'h0,        32'hFFFF8001, 1'b0};
    vt[8]  = '{1, 1'b1, 1'b0, F3_HU,  32'h22,  32'h0,        32'h00008001, 1'b0};
    vt[9]  = '{1, 1'b1, 1'b0, F3_W,   32'h06,  32'h0,        32'h0,        1'b1};
    vt[10] = '{1, 1'b1, 1'b1, F3_W,   32'h10,  32'h55555555, 32'h0,        1'b1};
    vt[11] = '{1, 1'b1, 1'b0, F3_W,   32'h10,  32'h0,        32'h80ADBEEF, 1'b0};
    vt[12] = '{1, 1'b0, 1'b1, F3_BU,  32'h10,  32'h11,       32'h0,        1'b1};
    vt[13] = '{1, 1'b1, 1'b0, F3_H,   32'h23,  32'h0,        32'h0,        1'b1};
    vt[14] = '{0, 1'b0, 1'b1, F3_W,   32'h0,   32'h1234,     32'h0,        1'b0};
    vt[15] = '{0, 1'b1, 1'b0, F3_W,   32'h0,   32'h0,        32'h1234,     1'b0};
    vt[16] = '{0, 1'b1, 1'b0, F3_W,   32'h100, 32'h0,        32'h1234,     1'b0};
    vt[17] = '{0, 1'b1, 1'b0, 3'b011, 32'h0,   32'h0,        32'h0,        1'b1};

    // Reset state, with an illegal request held on the lines throughout.
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; rd[d] = 1'b1; wr[d] = 1'b1; funct3[d] = 3'b111;
      addr[d] = 32'h3; wdata[d] = 32'h0;
    end
    repeat (2) @(negedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("reset rdata d%0d", d), rdata[d], 32'h0);
      check($sformatf("reset ready/busy/err d%0d", d), {29'h0, ready[d], busy[d], err[d]}, 32'h0);
      rd[d] = 1'b0; wr[d] = 1'b0;
    end
    @(negedge clk);
    rst[0] = 1'b0; rst[1] = 1'b0;

    // Directed table.
    for (int i = 0; i < 18; i++) begin
      run_and_check($sformatf("vec%0d", i), vt[i].d, vt[i].rd, vt[i].wr, vt[i].f3,
                    vt[i].addr, vt[i].wdata, vt[i].exp_rdata, vt[i].exp_err);
      if (!vt[i].exp_err && vt[i].wr) mdl_store(vt[i].d, vt[i].f3, vt[i].addr, vt[i].wdata);
    end

    // Request lines change during WAIT: the latched store must still land at 0x30.
    @(negedge clk);
    rd[1] = 1'b0; wr[1] = 1'b1; funct3[1] = F3_W; addr[1] = 32'h30; wdata[1] = 32'hCAFEF00D;
    @(negedge clk);
    addr[1] = 32'h34; wdata[1] = 32'h55555555;
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (ready[1]) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    check("held store ready", 32'(seen), 32'h1);
    wr[1] = 1'b0;
    mdl_store(1, F3_W, 32'h30, 32'hCAFEF00D);
    run_and_check("held store readback", 1, 1'b1, 1'b0, F3_W, 32'h30, 32'h0, 32'hCAFEF00D, 1'b0);

    // Reset during WAIT drops a pending store.
    @(negedge clk);
    rd[1] = 1'b0; wr[1] = 1'b1; funct3[1] = F3_W; addr[1] = 32'h10; wdata[1] = 32'h11111111;
    @(negedge clk);
    #1;
    check("wait busy", 32'(busy[1]), 32'h1);
    rst[1] = 1'b1;
    #1;
    check("rst in wait outs", {29'h0, ready[1], busy[1], err[1]}, 32'h0);
    rd[1] = 1'b1;
    #1;
    check("rst masks request", {29'h0, ready[1], busy[1], err[1]}, 32'h0);
    check("rst rdata", rdata[1], 32'h0);
    rd[1] = 1'b0; wr[1] = 1'b0;
    @(negedge clk);
    rst[1] = 1'b0;
    run_and_check("load after dropped store", 1, 1'b1, 1'b0, F3_W, 32'h10, 32'h0, 32'h80ADBEEF, 1'b0);

    // Reset during RESP drops ready at once.
    @(negedge clk);
    rd[1] = 1'b1; wr[1] = 1'b0; funct3[1] = F3_W; addr[1] = 32'h10;
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (ready[1]) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    check("resp reached", 32'(seen), 32'h1);
    check("resp data", rdata[1], 32'h80ADBEEF);
    rst[1] = 1'b1;
    rd[1] = 1'b0;
    #1;
    check("rst in resp ready", 32'(ready[1]), 32'h0);
    check("rst in resp rdata", rdata[1], 32'h0);
    @(negedge clk);
    rst[1] = 1'b0;

    // Randomized traffic against the byte model.
    for (int d = 0; d < 2; d++) begin
      base = (d == 0) ? 32'h80 : 32'h400;
      for (int k = 0; k < 16; k++) begin
        a  = base + 4 * k;
        wd = $urandom;
        run_and_check($sformatf("fill d%0d w%0d", d, k), d, 1'b0, 1'b1, F3_W, a, wd, 32'h0, 1'b0);
        mdl_store(d, F3_W, a, wd);
      end
      for (int k = 0; k < 120; k++) begin
        sel = $urandom_range(0, 9);
        r   = (sel <= 4);
        w   = (sel == 0) || (sel >= 5);
        if ($urandom_range(0, 4) == 0) f3 = 3'($urandom_range(0, 7));
        else begin
          case ($urandom_range(0, 4))
            0: f3 = F3_B;
            1: f3 = F3_H;
            2: f3 = F3_W;
            3: f3 = F3_BU;
            default: f3 = F3_HU;
          endcase
        end
        a  = base + $urandom_range(0, 63) + mdl_bytes(d) * $urandom_range(0, 7);
        wd = $urandom;
        leg    = mdl_legal(r, w, f3, a);
        exp_rd = (leg && r && !w) ? mdl_load(d, f3, a) : 32'h0;
        run_and_check($sformatf("rnd d%0d #%0d", d, k), d, r, w, f3, a, wd, exp_rd, !leg);
        if (leg && w) mdl_store(d, f3, a, wd);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the riscv-mini core. It is the memory-side end of the load/store request interface driven by the core's control decode (`mem_read`/`mem_write`). It accepts one load or store at a time, inserts a programmable number of wait states, performs byte/half/word access on an internal word-organised RAM with load sign/zero extension, and returns a one-cycle completion strobe. While an access is outstanding it holds the core via a stall output.

## Interface
- `DEPTH`, 1024: number of 32-bit words in the RAM; power of two.
- `LATENCY`, 2: wait cycles inserted between acceptance and commit; range 0–15.
- `clk_i`  in  1  single clock.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `mem_read_i`  in  1  load request; held by the core until `ready_o`.
- `mem_write_i`  in  1  store request; held by the core until `ready_o`.
- `addr_i`  in  32  byte address.
- `wdata_i`  in  32  store data, right-aligned.
- `funct3_i`  in  3  access size and sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `rdata_o`  out  32  load result, extended; valid only while `ready_o`.
- `ready_o`  out  1  one-cycle completion strobe.
- `busy_o`  out  1  stall to the core; combinational.
- `err_o`  out  1  one-cycle strobe on a rejected request.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE, no request: outputs low.
- IDLE, a request is rejected if any of the following holds:
  - both `mem_read_i` and `mem_write_i` are high;
  - the halfword address is odd;
  - the word address is not 4-aligned;
  - `funct3_i` is illegal. For stores, only 000, 001 and 010 are legal.
- On rejection: `err_o` pulses that cycle, `ready_o` pulses that cycle, the state stays IDLE, and there is no RAM access.
- IDLE, legal request: latch addr/wdata/funct3/dir. Go to WAIT with the counter set to LATENCY−1, or go directly to RESP when LATENCY=0.
- WAIT: the counter decrements each cycle. At 0 the access commits and the state moves to RESP.
  - Store commit: a byte-enabled write to the RAM, with the byte lane taken from `addr[1:0]`.
  - Load commit: the read word is captured.
- RESP: `ready_o`=1. For a load, `rdata_o` carries the lane selected by `addr[1:0]`, then sign- or zero-extended per `funct3`. For a store, `rdata_o`=0. Next state is IDLE.
- Request inputs seen in RESP are ignored; they are the old request still held by the core.
- RAM index is `addr[log2(DEPTH)+1:2]`. Upper address bits are ignored, so addresses wrap modulo 4·DEPTH.
- `busy_o` = (IDLE and legal request) or WAIT. It is low in RESP and on rejection.
- `rdata_o` = 0 whenever `ready_o` = 0.

## Timing
- Reset values: state IDLE, counter 0, `rdata_o`/`ready_o`/`busy_o`/`err_o` = 0. RAM contents are not reset.
- Load/store latency: `ready_o` is asserted LATENCY+1 cycles after the acceptance edge. For LATENCY=0 this is the cycle after acceptance.
- Store data is visible to a load accepted in any cycle after the store's RESP cycle.
- A read-after-write to the same address via back-to-back requests returns the new data.
- Reset asserted in WAIT: the access is dropped and a pending store is not written. Reset asserted in RESP: `ready_o` drops immediately.
- The core must hold its request stable while `busy_o` is high. Changes during WAIT are ignored, because the latched copies are used.

## Structure
- `mem_pkg` holds:
  - funct3 constants: `F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`;
  - the state enum `dmem_state_t`;
  - the `L_OP`/`S_OP` opcode constants shared with control decode.
- Sub-module `dmem_array`: synchronous single-port RAM, DEPTH×32, with a 4-bit byte-enable write and a registered read. The responder contains the FSM, counter, lane alignment/extension logic and alignment checks.

## Test plan
- LATENCY=2, SW 0xDEADBEEF to 0x10, then LW 0x10 → `busy_o` for 3 cycles each; `ready_o` in the 3rd cycle after acceptance; `rdata_o`=0xDEADBEEF.
- SB 0x80 to 0x13, then LB 0x13 → 0xFFFFFF80; LBU 0x13 → 0x00000080; LW 0x10 → 0x80ADBEEF.
- SH 0x8001 to 0x22, then LH 0x22 → 0xFFFF8001; LHU → 0x00008001.
- LW at 0x06 → `err_o`=1 and `ready_o`=1 in the same cycle, `busy_o`=0, RAM unchanged. Repeat with read and write both high → `err_o`=1.
- LATENCY=0, back-to-back SW 0x1234 at 0x0 then LW 0x0 → each completes in 2 cycles; the load returns 0x1234. A load at 4·DEPTH returns the same data as address 0x0 (wrap).
- Store accepted, `rst_i` pulsed during WAIT, then LW same address → returns the pre-store value; all outputs are 0 during reset.
